// File: rtl/branch_resolve_unit_pkg.sv
// Shared CPU definitions for branch prediction and resolution.
// The bType encoding is common to the predictor and the resolve unit.
package branch_resolve_unit_pkg;

    localparam logic [1:0] BT_OTHER = 2'b00;
    localparam logic [1:0] BT_JAL   = 2'b01;
    localparam logic [1:0] BT_BR    = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pTaken;
        logic [31:0] pTarget;
    } pred_slot_t;

endpackage

// File: rtl/br_pred_pipe.sv
// Two-stage IF/ID -> ID/EX shadow register for the fetch-time prediction.
// Advances on adv_i; a squash at the same edge turns both slots into bubbles.
module br_pred_pipe
    import branch_resolve_unit_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       adv_i,
    input  logic       squash_i,
    input  pred_slot_t if_slot_i,
    output pred_slot_t id_slot_o,
    output pred_slot_t ex_slot_o
);

    pred_slot_t id_q, id_d;
    pred_slot_t ex_q, ex_d;

    always_comb begin
        id_d = id_q;
        ex_d = ex_q;
        if (adv_i) begin
            id_d = if_slot_i;
            ex_d = id_q;
            // Squash wins over the instruction being fetched this edge.
            if (squash_i) begin
                id_d.valid = 1'b0;
                ex_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q <= '0;
            ex_q <= '0;
        end else begin
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

    assign id_slot_o = id_q;
    assign ex_slot_o = ex_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the EX-stage branch against its carried prediction, drives the
// predictor update bus and redirect/flush, and keeps branch/mispredict counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IF_DONE,
    input  logic                 MEM_DONE,
    input  logic [31:0]          IF_PC,
    input  logic                 IF_pTaken,
    input  logic [31:0]          IF_pTarget,
    input  logic [1:0]           EX_bTypeIn,
    input  logic                 EX_cond,
    input  logic [31:0]          EX_imm,
    output logic [1:0]           EX_bType,
    output logic                 EX_rTaken,
    output logic [31:0]          EX_PC,
    output logic [31:0]          EX_bTarget,
    output logic                 redirect,
    output logic [31:0]          redirect_PC,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    logic       adv;
    pred_slot_t if_slot, id_slot, ex_slot;
    logic [1:0] bt_dec;
    logic [31:0] target, seq_pc;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

    assign adv = IF_DONE && MEM_DONE;

    assign if_slot = '{valid: 1'b1, pc: IF_PC, pTaken: IF_pTaken, pTarget: IF_pTarget};

    br_pred_pipe u_pipe (
        .clk_i     (clk),
        .rst_ni    (rst),
        .adv_i     (adv),
        .squash_i  (redirect),
        .if_slot_i (if_slot),
        .id_slot_o (id_slot),
        .ex_slot_o (ex_slot)
    );

    // Encoding 11 is not a control transfer.
    assign bt_dec = (EX_bTypeIn == BT_JAL || EX_bTypeIn == BT_BR) ? EX_bTypeIn : BT_OTHER;
    assign target = ex_slot.pc + EX_imm;
    assign seq_pc = ex_slot.pc + 32'd4;

    always_comb begin
        EX_bType    = BT_OTHER;
        EX_rTaken   = 1'b0;
        EX_PC       = '0;
        EX_bTarget  = '0;
        redirect    = 1'b0;
        redirect_PC = '0;
        if (ex_slot.valid) begin
            EX_bType   = bt_dec;
            EX_PC      = ex_slot.pc;
            EX_bTarget = target;
            case (bt_dec)
                BT_BR: begin
                    EX_rTaken = EX_cond;
                    redirect  = (ex_slot.pTaken != EX_cond) ||
                                (ex_slot.pTaken && EX_cond && ex_slot.pTarget != target);
                end
                BT_JAL: begin
                    EX_rTaken = 1'b1;
                    redirect  = !ex_slot.pTaken || (ex_slot.pTarget != target);
                end
                default: begin
                    EX_rTaken = 1'b0;
                    redirect  = ex_slot.pTaken;
                end
            endcase
            redirect_PC = EX_rTaken ? target : seq_pc;
        end
    end

    assign flush = redirect;

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (adv) begin
            if (ex_slot.valid && bt_dec != BT_OTHER) begin
                br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
            end
            if (redirect) begin
                miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: prediction pipeline, resolution,
// stall stability, squash, counters and asynchronous reset.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        IF_DONE, MEM_DONE;
    logic [31:0] IF_PC, IF_pTarget, EX_imm;
    logic        IF_pTaken, EX_cond;
    logic [1:0]  EX_bTypeIn;
    logic [1:0]  EX_bType;
    logic        EX_rTaken, redirect, flush;
    logic [31:0] EX_PC, EX_bTarget, redirect_PC;
    logic [31:0] br_cnt, miss_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.CNT_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .IF_DONE     (IF_DONE),
        .MEM_DONE    (MEM_DONE),
        .IF_PC       (IF_PC),
        .IF_pTaken   (IF_pTaken),
        .IF_pTarget  (IF_pTarget),
        .EX_bTypeIn  (EX_bTypeIn),
        .EX_cond     (EX_cond),
        .EX_imm      (EX_imm),
        .EX_bType    (EX_bType),
        .EX_rTaken   (EX_rTaken),
        .EX_PC       (EX_PC),
        .EX_bTarget  (EX_bTarget),
        .redirect    (redirect),
        .redirect_PC (redirect_PC),
        .flush       (flush),
        .br_cnt      (br_cnt),
        .miss_cnt    (miss_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch pc, then a non-predicted filler; afterwards pc sits in EX.
    task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        EX_bTypeIn = BT_OTHER;
        EX_cond    = 1'b0;
        IF_PC      = pc;
        IF_pTaken  = pt;
        IF_pTarget = tgt;
        step();
        IF_PC      = pc + 32'd4;
        IF_pTaken  = 1'b0;
        IF_pTarget = 32'd0;
        step();
    endtask

    task automatic set_ex(input logic [1:0] bt, input logic c, input logic [31:0] imm);
        EX_bTypeIn = bt;
        EX_cond    = c;
        EX_imm     = imm;
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        IF_DONE    = 1'b1;
        MEM_DONE   = 1'b1;
        IF_PC      = 32'd0;
        IF_pTaken  = 1'b0;
        IF_pTarget = 32'd0;
        EX_bTypeIn = BT_OTHER;
        EX_cond    = 1'b0;
        EX_imm     = 32'd0;
        #12;

        // Reset state
        chk("rst_redirect", {63'd0, redirect}, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_bType", {62'd0, EX_bType}, 64'd0);
        chk("rst_EX_PC", {32'd0, EX_PC}, 64'd0);
        chk("rst_redirect_PC", {32'd0, redirect_PC}, 64'd0);
        chk("rst_br_cnt", {32'd0, br_cnt}, 64'd0);
        chk("rst_miss_cnt", {32'd0, miss_cnt}, 64'd0);
        rst = 1'b1;
        #1;

        // 1: Btype not predicted, actually taken
        issue(32'h100, 1'b0, 32'h0);
        set_ex(BT_BR, 1'b1, 32'h20);
        chk("s1_EX_PC", {32'd0, EX_PC}, 64'h100);
        chk("s1_redirect", {63'd0, redirect}, 64'd1);
        chk("s1_flush", {63'd0, flush}, 64'd1);
        chk("s1_redirect_PC", {32'd0, redirect_PC}, 64'h120);
        chk("s1_rTaken", {63'd0, EX_rTaken}, 64'd1);
        chk("s1_bTarget", {32'd0, EX_bTarget}, 64'h120);
        chk("s1_bType", {62'd0, EX_bType}, 64'(BT_BR));
        IF_PC = 32'h120;
        step();
        chk("s1_post_redirect", {63'd0, redirect}, 64'd0);
        chk("s1_post_EX_PC", {32'd0, EX_PC}, 64'd0);
        chk("s1_miss_cnt", {32'd0, miss_cnt}, 64'd1);
        chk("s1_br_cnt", {32'd0, br_cnt}, 64'd1);
        step();
        chk("s1_id_squashed", {32'd0, EX_PC}, 64'd0);

        // 2: Btype correctly predicted taken
        issue(32'h100, 1'b1, 32'h120);
        set_ex(BT_BR, 1'b1, 32'h20);
        chk("s2_redirect", {63'd0, redirect}, 64'd0);
        chk("s2_rTaken", {63'd0, EX_rTaken}, 64'd1);
        chk("s2_bTarget", {32'd0, EX_bTarget}, 64'h120);
        step();
        EX_bTypeIn = BT_OTHER;
        #1;
        chk("s2_br_cnt", {32'd0, br_cnt}, 64'd2);
        chk("s2_miss_cnt", {32'd0, miss_cnt}, 64'd1);

        // 3: aliasing hit on a non-branch
        issue(32'h200, 1'b1, 32'h999);
        set_ex(BT_OTHER, 1'b0, 32'h40);
        chk("s3_redirect", {63'd0, redirect}, 64'd1);
        chk("s3_redirect_PC", {32'd0, redirect_PC}, 64'h204);
        chk("s3_bType", {62'd0, EX_bType}, 64'd0);
        chk("s3_rTaken", {63'd0, EX_rTaken}, 64'd0);
        step();
        chk("s3_br_cnt", {32'd0, br_cnt}, 64'd2);
        chk("s3_miss_cnt", {32'd0, miss_cnt}, 64'd2);

        // 4: JAL with wrong target, held in a stall
        issue(32'h300, 1'b1, 32'h400);
        set_ex(BT_JAL, 1'b0, 32'h80);
        chk("s4_redirect", {63'd0, redirect}, 64'd1);
        chk("s4_redirect_PC", {32'd0, redirect_PC}, 64'h380);
        chk("s4_bType", {62'd0, EX_bType}, 64'(BT_JAL));
        MEM_DONE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s4_stall_redirect", {63'd0, redirect}, 64'd1);
            chk("s4_stall_redirect_PC", {32'd0, redirect_PC}, 64'h380);
            chk("s4_stall_EX_PC", {32'd0, EX_PC}, 64'h300);
            chk("s4_stall_miss_cnt", {32'd0, miss_cnt}, 64'd2);
            chk("s4_stall_br_cnt", {32'd0, br_cnt}, 64'd2);
        end
        MEM_DONE = 1'b1;
        step();
        chk("s4_miss_cnt", {32'd0, miss_cnt}, 64'd3);
        chk("s4_br_cnt", {32'd0, br_cnt}, 64'd3);
        chk("s4_post_redirect", {63'd0, redirect}, 64'd0);

        // 5: back-to-back Btypes, first mispredicts, second squashed
        IF_PC = 32'h500; IF_pTaken = 1'b0; IF_pTarget = 32'h0;
        step();
        IF_PC = 32'h504;
        step();
        set_ex(BT_BR, 1'b1, 32'h10);
        chk("s5_EX_PC", {32'd0, EX_PC}, 64'h500);
        chk("s5_redirect_PC", {32'd0, redirect_PC}, 64'h510);
        IF_PC = 32'h510;
        step();
        chk("s5_miss_cnt", {32'd0, miss_cnt}, 64'd4);
        step();
        chk("s5_second_squashed", {32'd0, EX_PC}, 64'd0);
        chk("s5_second_redirect", {63'd0, redirect}, 64'd0);
        chk("s5_br_cnt", {32'd0, br_cnt}, 64'd4);
        chk("s5_miss_cnt_once", {32'd0, miss_cnt}, 64'd4);

        // PC+4 and PC+imm wrap modulo 2^32
        issue(32'hFFFF_FFFC, 1'b0, 32'h0);
        set_ex(BT_OTHER, 1'b0, 32'h8);
        chk("wrap_redirect", {63'd0, redirect}, 64'd0);
        chk("wrap_redirect_PC", {32'd0, redirect_PC}, 64'd0);
        chk("wrap_bTarget", {32'd0, EX_bTarget}, 64'h4);

        // 6: reset during a stalled redirect
        issue(32'h600, 1'b1, 32'h700);
        set_ex(BT_OTHER, 1'b0, 32'h0);
        MEM_DONE = 1'b0;
        step();
        chk("s6_stalled_redirect", {63'd0, redirect}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("s6_rst_redirect", {63'd0, redirect}, 64'd0);
        chk("s6_rst_br_cnt", {32'd0, br_cnt}, 64'd0);
        chk("s6_rst_miss_cnt", {32'd0, miss_cnt}, 64'd0);
        chk("s6_rst_EX_PC", {32'd0, EX_PC}, 64'd0);
        step();
        rst = 1'b1;
        MEM_DONE = 1'b1;
        IF_PC = 32'h100; IF_pTaken = 1'b1; IF_pTarget = 32'h120;
        EX_bTypeIn = BT_BR; EX_cond = 1'b1; EX_imm = 32'h20;
        step();
        chk("s6_first_edge_EX_PC", {32'd0, EX_PC}, 64'd0);
        IF_PC = 32'h104; IF_pTaken = 1'b0; IF_pTarget = 32'h0;
        step();
        chk("s6_EX_PC", {32'd0, EX_PC}, 64'h100);
        chk("s6_redirect", {63'd0, redirect}, 64'd0);
        chk("s6_rTaken", {63'd0, EX_rTaken}, 64'd1);
        chk("s6_bTarget", {32'd0, EX_bTarget}, 64'h120);
        chk("s6_br_cnt_pre", {32'd0, br_cnt}, 64'd0);
        step();
        chk("s6_br_cnt", {32'd0, br_cnt}, 64'd1);
        chk("s6_miss_cnt", {32'd0, miss_cnt}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
